// File: rtl/mastermind_engine.sv
// Mastermind scoring engine: cursor-driven guess editing, serial exact/partial
// scoring with per-colour histograms, and a history write per scored guess.
module mastermind_engine #(
   parameter int SLOTS       = 4,
   parameter int COLOR_W     = 3,
   parameter int MAX_GUESSES = 8,
   localparam int CNT_W      = $clog2(SLOTS + 1),
   localparam int GN_W       = $clog2(MAX_GUESSES),
   localparam int CUR_W      = $clog2(SLOTS)
) (
   input  logic                              Clk,
   input  logic                              Reset_n,
   input  logic [SLOTS*COLOR_W-1:0]          secret,
   input  logic [COLOR_W-1:0]                color_in,
   input  logic                              new_game,
   input  logic                              confirm_color,
   input  logic                              check_guess,
   input  logic                              btn_left,
   input  logic                              btn_right,
   output logic [CUR_W-1:0]                  cursor,
   output logic [SLOTS*COLOR_W-1:0]          current_guess,
   output logic [GN_W-1:0]                   guess_num,
   output logic [CNT_W-1:0]                  exact_cnt,
   output logic [CNT_W-1:0]                  partial_cnt,
   output logic                              fb_valid,
   output logic                              guess_err,
   output logic                              hist_we,
   output logic [GN_W-1:0]                   hist_addr,
   output logic [SLOTS*COLOR_W+2*CNT_W-1:0]  hist_data,
   output logic                              q_Start,
   output logic                              q_Input,
   output logic                              q_Check,
   output logic                              q_DoneC,
   output logic                              q_DoneNC
);

   localparam int NCOL  = 1 << COLOR_W;
   localparam int IDX_W = (COLOR_W > CUR_W) ? COLOR_W : CUR_W;

   localparam logic [CUR_W-1:0] LAST_CUR  = CUR_W'(SLOTS - 1);
   localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(SLOTS - 1);
   localparam logic [IDX_W-1:0] LAST_COL  = IDX_W'(NCOL - 1);
   localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);
   localparam logic [GN_W-1:0]  LAST_GN   = GN_W'(MAX_GUESSES - 1);
   localparam logic [GN_W-1:0]  ONE_GN    = GN_W'(1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(SLOTS);
   localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_START, ST_INPUT, ST_CHECK_EX, ST_CHECK_PC, ST_REPORT, ST_DONE_C, ST_DONE_NC
   } state_e;

   state_e                           state_q;
   logic [CUR_W-1:0]                 cursor_q, cursor_d;
   logic [COLOR_W-1:0]               guess_q [SLOTS];
   logic [COLOR_W-1:0]               guess_d [SLOTS];
   logic [COLOR_W-1:0]               secret_q [SLOTS];
   logic [GN_W-1:0]                  gn_q;
   logic [IDX_W-1:0]                 step_q;
   logic [CNT_W-1:0]                 ex_q, pc_q, exact_q, partial_q;
   logic [CNT_W-1:0]                 sh_q [NCOL];
   logic [CNT_W-1:0]                 gh_q [NCOL];
   logic                             fb_q, err_q;
   logic [GN_W-1:0]                  hist_addr_q;
   logic [SLOTS*COLOR_W+2*CNT_W-1:0] hist_data_q;
   logic [SLOTS*COLOR_W-1:0]         guess_flat;
   logic                             filled, restart;
   logic [COLOR_W-1:0]               sc, gc;
   logic [CNT_W-1:0]                 bin_min;

   always_comb begin
      guess_d = guess_q;
      if (confirm_color) guess_d[cursor_q] = color_in;

      cursor_d = cursor_q;
      if (btn_right && !btn_left)
         cursor_d = (cursor_q == LAST_CUR) ? '0 : cursor_q + CUR_W'(1);
      else if (btn_left && !btn_right)
         cursor_d = (cursor_q == '0) ? LAST_CUR : cursor_q - CUR_W'(1);

      filled = 1'b1;
      for (int unsigned i = 0; i < SLOTS; i++)
         if (guess_d[i] == '0) filled = 1'b0;

      guess_flat = '0;
      for (int unsigned i = 0; i < SLOTS; i++)
         guess_flat[i*COLOR_W +: COLOR_W] = guess_q[i];

      restart = new_game && (state_q inside {ST_START, ST_INPUT, ST_DONE_C, ST_DONE_NC});

      sc      = secret_q[step_q[CUR_W-1:0]];
      gc      = guess_q[step_q[CUR_W-1:0]];
      bin_min = (sh_q[step_q[COLOR_W-1:0]] < gh_q[step_q[COLOR_W-1:0]])
                ? sh_q[step_q[COLOR_W-1:0]] : gh_q[step_q[COLOR_W-1:0]];
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= ST_START;
         cursor_q    <= '0;
         gn_q        <= '0;
         step_q      <= '0;
         ex_q        <= '0;
         pc_q        <= '0;
         exact_q     <= '0;
         partial_q   <= '0;
         fb_q        <= 1'b0;
         err_q       <= 1'b0;
         hist_addr_q <= '0;
         hist_data_q <= '0;
         for (int unsigned i = 0; i < SLOTS; i++) begin
            guess_q[i]  <= '0;
            secret_q[i] <= '0;
         end
         for (int unsigned c = 0; c < NCOL; c++) begin
            sh_q[c] <= '0;
            gh_q[c] <= '0;
         end
      end else begin
         fb_q  <= 1'b0;
         err_q <= 1'b0;
         if (restart) begin
            state_q   <= ST_INPUT;
            cursor_q  <= '0;
            gn_q      <= '0;
            exact_q   <= '0;
            partial_q <= '0;
            for (int unsigned i = 0; i < SLOTS; i++) begin
               guess_q[i]  <= '0;
               secret_q[i] <= secret[i*COLOR_W +: COLOR_W];
            end
         end else begin
            unique case (state_q)
               ST_INPUT: begin
                  // The write lands before the fill check, so a same-cycle
                  // confirm can complete the guess that is being submitted.
                  guess_q  <= guess_d;
                  cursor_q <= cursor_d;
                  if (check_guess) begin
                     if (filled) begin
                        state_q <= ST_CHECK_EX;
                        step_q  <= '0;
                        ex_q    <= '0;
                        pc_q    <= '0;
                        for (int unsigned c = 0; c < NCOL; c++) begin
                           sh_q[c] <= '0;
                           gh_q[c] <= '0;
                        end
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end
               ST_CHECK_EX: begin
                  if (sc == gc) begin
                     ex_q <= ex_q + ONE_CNT;
                  end else begin
                     sh_q[sc] <= sh_q[sc] + ONE_CNT;
                     gh_q[gc] <= gh_q[gc] + ONE_CNT;
                  end
                  if (step_q == LAST_SLOT) begin
                     state_q <= ST_CHECK_PC;
                     step_q  <= ONE_IDX;
                  end else begin
                     step_q <= step_q + ONE_IDX;
                  end
               end
               ST_CHECK_PC: begin
                  // Colour 0 bins are never visited, so an empty secret slot cannot score.
                  pc_q <= pc_q + bin_min;
                  if (step_q == LAST_COL) state_q <= ST_REPORT;
                  else                    step_q  <= step_q + ONE_IDX;
               end
               ST_REPORT: begin
                  fb_q        <= 1'b1;
                  exact_q     <= ex_q;
                  partial_q   <= pc_q;
                  hist_addr_q <= gn_q;
                  hist_data_q <= {pc_q, ex_q, guess_flat};
                  if (ex_q == FULL_CNT) begin
                     state_q <= ST_DONE_C;
                  end else if (gn_q == LAST_GN) begin
                     state_q <= ST_DONE_NC;
                  end else begin
                     state_q  <= ST_INPUT;
                     gn_q     <= gn_q + ONE_GN;
                     cursor_q <= '0;
                     for (int unsigned i = 0; i < SLOTS; i++) guess_q[i] <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign cursor        = cursor_q;
   assign current_guess = guess_flat;
   assign guess_num     = gn_q;
   assign exact_cnt     = exact_q;
   assign partial_cnt   = partial_q;
   assign fb_valid      = fb_q;
   assign hist_we       = fb_q;
   assign guess_err     = err_q;
   assign hist_addr     = hist_addr_q;
   assign hist_data     = hist_data_q;
   assign q_Start       = (state_q == ST_START);
   assign q_Input       = (state_q == ST_INPUT);
   assign q_Check       = (state_q inside {ST_CHECK_EX, ST_CHECK_PC, ST_REPORT});
   assign q_DoneC       = (state_q == ST_DONE_C);
   assign q_DoneNC      = (state_q == ST_DONE_NC);

endmodule

// File: tb/tb_mastermind_engine.sv
// Directed and randomized games against a counting-based Mastermind scorer.
module tb_mastermind_engine;
   localparam int SLOTS = 4, COLOR_W = 3, MAXG = 8;
   localparam int CNT_W = 3, GN_W = 3, CUR_W = 2;
   localparam int NC  = (1 << COLOR_W) - 1;
   localparam int LAT = SLOTS + (1 << COLOR_W);

   logic                             Clk = 1'b0, Reset_n = 1'b0;
   logic [SLOTS*COLOR_W-1:0]         secret = '0;
   logic [COLOR_W-1:0]               color_in = '0;
   logic                             new_game = 1'b0, confirm_color = 1'b0, check_guess = 1'b0;
   logic                             btn_left = 1'b0, btn_right = 1'b0;
   logic [CUR_W-1:0]                 cursor;
   logic [SLOTS*COLOR_W-1:0]         current_guess;
   logic [GN_W-1:0]                  guess_num, hist_addr;
   logic [CNT_W-1:0]                 exact_cnt, partial_cnt;
   logic                             fb_valid, guess_err, hist_we;
   logic [SLOTS*COLOR_W+2*CNT_W-1:0] hist_data;
   logic                             q_Start, q_Input, q_Check, q_DoneC, q_DoneNC;

   int total = 0, passed = 0, gn_exp = 0;
   int sv[SLOTS], gv[SLOTS];
   bit done;

   mastermind_engine #(.SLOTS(SLOTS), .COLOR_W(COLOR_W), .MAX_GUESSES(MAXG)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .secret(secret), .color_in(color_in),
      .new_game(new_game), .confirm_color(confirm_color), .check_guess(check_guess),
      .btn_left(btn_left), .btn_right(btn_right), .cursor(cursor),
      .current_guess(current_guess), .guess_num(guess_num), .exact_cnt(exact_cnt),
      .partial_cnt(partial_cnt), .fb_valid(fb_valid), .guess_err(guess_err),
      .hist_we(hist_we), .hist_addr(hist_addr), .hist_data(hist_data),
      .q_Start(q_Start), .q_Input(q_Input), .q_Check(q_Check),
      .q_DoneC(q_DoneC), .q_DoneNC(q_DoneNC)
   );

   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [SLOTS*COLOR_W-1:0] pack(input int a[SLOTS]);
      logic [SLOTS*COLOR_W-1:0] r = '0;
      for (int i = 0; i < SLOTS; i++) r[i*COLOR_W +: COLOR_W] = COLOR_W'(a[i]);
      return r;
   endfunction

   // Classic rule: exact positions, plus per-colour min counts minus the exact hits.
   function automatic void score(output int e, output int p);
      int tot = 0;
      e = 0;
      for (int i = 0; i < SLOTS; i++) if (sv[i] == gv[i]) e++;
      for (int c = 1; c <= NC; c++) begin
         int cs = 0, cg = 0;
         for (int i = 0; i < SLOTS; i++) begin
            if (sv[i] == c) cs++;
            if (gv[i] == c) cg++;
         end
         tot += (cs < cg) ? cs : cg;
      end
      p = tot - e;
   endfunction

   function automatic logic [4:0] flags();
      return {q_Start, q_Input, q_Check, q_DoneC, q_DoneNC};
   endfunction

   task automatic start_game();
      secret   = pack(sv);
      new_game = 1'b1;
      step();
      new_game = 1'b0;
      gn_exp   = 0;
      chk("newgame_flags", flags(), 5'b01000);
      chk("newgame_gn", guess_num, 0);
      chk("newgame_cursor", cursor, 0);
      chk("newgame_guess", current_guess, 0);
   endtask

   task automatic enter_guess();
      for (int i = 0; i < SLOTS; i++) begin
         color_in      = COLOR_W'(gv[i]);
         confirm_color = 1'b1;
         btn_right     = 1'b1;
         step();
         confirm_color = 1'b0;
         btn_right     = 1'b0;
      end
      chk("entered_guess", current_guess, pack(gv));
      chk("entered_cursor", cursor, 0);
   endtask

   task automatic await_feedback(output bit fin);
      int n = 0, e, p;
      while (fb_valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      score(e, p);
      chk("fb_latency", n, LAT);
      chk("exact", exact_cnt, e);
      chk("partial", partial_cnt, p);
      chk("hist_we", hist_we, 1);
      chk("hist_addr", hist_addr, gn_exp);
      chk("hist_data", hist_data, {CNT_W'(p), CNT_W'(e), pack(gv)});
      fin = 1'b1;
      if (e == SLOTS) begin
         chk("flags_donec", flags(), 5'b00010);
      end else if (gn_exp == MAXG - 1) begin
         chk("flags_donenc", flags(), 5'b00001);
      end else begin
         fin = 1'b0;
         gn_exp++;
         chk("flags_next", flags(), 5'b01000);
         chk("next_gn", guess_num, gn_exp);
         chk("next_guess", current_guess, 0);
         chk("next_cursor", cursor, 0);
      end
      step();
      chk("fb_pulse_end", fb_valid, 0);
   endtask

   task automatic submit(output bit fin);
      check_guess = 1'b1;
      step();
      check_guess = 1'b0;
      chk("accept_no_err", guess_err, 0);
      chk("accept_check", q_Check, 1);
      await_feedback(fin);
   endtask

   task automatic random_guess(input bit allow_win);
      for (int i = 0; i < SLOTS; i++) gv[i] = $urandom_range(NC, 1);
      if (allow_win && $urandom_range(4, 0) == 0) gv = sv;
      if (!allow_win && gv == sv) gv[0] = (sv[0] % NC) + 1;
   endtask

   initial begin
      int fb_seen;
      #1;
      chk("rst_flags", flags(), 5'b10000);
      chk("rst_cursor", cursor, 0);
      chk("rst_guess", current_guess, 0);
      chk("rst_gn", guess_num, 0);
      chk("rst_exact", exact_cnt, 0);
      chk("rst_partial", partial_cnt, 0);
      chk("rst_pulses", {fb_valid, guess_err, hist_we}, 3'b000);
      #20;
      Reset_n = 1'b1;
      step();

      // Editing inputs before any new_game must do nothing.
      repeat (6) begin
         color_in      = COLOR_W'($urandom_range(NC, 1));
         confirm_color = 1'($urandom);
         btn_left      = 1'($urandom);
         btn_right     = 1'($urandom);
         check_guess   = 1'($urandom);
         step();
         {confirm_color, btn_left, btn_right, check_guess} = '0;
      end
      chk("idle_flags", flags(), 5'b10000);
      chk("idle_guess", current_guess, 0);
      chk("idle_cursor", cursor, 0);
      chk("idle_err", guess_err, 0);

      sv = '{1, 2, 3, 4};
      start_game();
      btn_left = 1'b1; step(); btn_left = 1'b0;
      chk("cursor_wrap_left", cursor, 3);
      btn_left = 1'b1; btn_right = 1'b1; step(); btn_left = 1'b0; btn_right = 1'b0;
      chk("cursor_both", cursor, 3);
      btn_right = 1'b1; step(); btn_right = 1'b0;
      chk("cursor_wrap_right", cursor, 0);

      gv = '{1, 2, 0, 4};
      enter_guess();
      check_guess = 1'b1; step(); check_guess = 1'b0;
      chk("empty_err", guess_err, 1);
      chk("empty_flags", flags(), 5'b01000);
      step();
      chk("err_pulse_end", guess_err, 0);

      btn_right = 1'b1; step(); step(); btn_right = 1'b0;
      chk("cursor_slot2", cursor, 2);
      gv[2] = 3;
      color_in = 3'd3; confirm_color = 1'b1; check_guess = 1'b1;
      step();
      confirm_color = 1'b0; check_guess = 1'b0;
      chk("write_then_check", q_Check, 1);
      await_feedback(done);
      chk("win_exact", exact_cnt, 4);

      color_in = 3'd5; confirm_color = 1'b1; btn_right = 1'b1; check_guess = 1'b1;
      step();
      {confirm_color, btn_right, check_guess} = '0;
      step();
      chk("donec_hold_flags", flags(), 5'b00010);
      chk("donec_hold_cursor", cursor, 2);
      chk("donec_hold_guess", current_guess, pack(gv));
      chk("donec_hold_fb", {exact_cnt, partial_cnt, fb_valid, guess_err}, {3'd4, 3'd0, 2'b00});

      sv = '{1, 1, 2, 3};
      start_game();
      gv = '{1, 2, 1, 1};
      enter_guess();
      submit(done);
      chk("dup_exact", exact_cnt, 1);
      chk("dup_partial", partial_cnt, 2);
      while (!done) begin
         random_guess(1'b1);
         enter_guess();
         submit(done);
      end

      for (int g = 0; g < 3; g++) begin
         for (int i = 0; i < SLOTS; i++) sv[i] = $urandom_range(NC, 1);
         start_game();
         done = 1'b0;
         while (!done) begin
            random_guess(1'b1);
            enter_guess();
            submit(done);
         end
      end

      for (int i = 0; i < SLOTS; i++) sv[i] = $urandom_range(NC, 1);
      start_game();
      for (int k = 0; k < MAXG; k++) begin
         random_guess(1'b0);
         enter_guess();
         submit(done);
      end
      chk("lose_done", done, 1);
      chk("lose_flags", flags(), 5'b00001);
      start_game();

      random_guess(1'b1);
      enter_guess();
      check_guess = 1'b1; step(); check_guess = 1'b0;
      repeat (6) step();
      chk("mid_check", q_Check, 1);
      Reset_n = 1'b0;
      #1;
      chk("midrst_flags", flags(), 5'b10000);
      chk("midrst_counts", {exact_cnt, partial_cnt, guess_num, cursor}, '0);
      chk("midrst_guess", current_guess, 0);
      chk("midrst_pulses", {fb_valid, guess_err, hist_we}, 3'b000);
      #3;
      Reset_n = 1'b1;
      fb_seen = 0;
      repeat (20) begin
         step();
         if (fb_valid === 1'b1) fb_seen++;
      end
      chk("midrst_no_fb", fb_seen, 0);
      chk("midrst_stay_start", flags(), 5'b10000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
